// File: rtl/mnist_sequencer.sv
// Time-multiplexed MNIST inference controller: 784->128 dense, ReLU, 128->10 dense, argmax on one MAC.
// Build option: define MNIST_SEQ_RELU_EN to clamp hidden activations at zero (otherwise linear).
module mnist_sequencer #(
   parameter int unsigned IN_SIZE  = 784,
   parameter int unsigned HID_SIZE = 128,
   parameter int unsigned OUT_SIZE = 10,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned IDX_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  class_idx,
   output logic [31:0]       class_score,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [31:0]       img_rdata,
   output logic              w_sel,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [31:0]       w_rdata,
   output logic              hid_we,
   output logic [ADDR_W-1:0] hid_addr,
   output logic [31:0]       hid_wdata,
   input  logic [31:0]       hid_rdata
);

   localparam logic [ADDR_W-1:0] K1_LAST  = ADDR_W'(IN_SIZE - 1);
   localparam logic [ADDR_W-1:0] J1_LAST  = ADDR_W'(HID_SIZE - 1);
   localparam logic [ADDR_W-1:0] K2_LAST  = ADDR_W'(HID_SIZE - 1);
   localparam logic [ADDR_W-1:0] J2_LAST  = ADDR_W'(OUT_SIZE - 1);
   localparam logic [ADDR_W-1:0] HID_STEP = ADDR_W'(HID_SIZE);
   localparam logic [ADDR_W-1:0] OUT_STEP = ADDR_W'(OUT_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_L1_MAC, S_L1_WB, S_L2_MAC, S_L2_CMP, S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_k;
   logic [ADDR_W-1:0]  r_j;
   logic [31:0]        r_acc;
   logic [31:0]        r_best;
   logic [IDX_W-1:0]   r_best_idx;
   logic               r_busy;
   logic               r_done;
   logic [IDX_W-1:0]   r_class_idx;
   logic [31:0]        r_class_score;
   logic [ADDR_W-1:0]  r_img_addr;
   logic               r_w_sel;
   logic [ADDR_W-1:0]  r_w_addr;
   logic               r_hid_we;
   logic [ADDR_W-1:0]  r_hid_addr;

   logic [31:0]        w_opa;
   logic [31:0]        w_prod;
   logic               w_add_en;
   logic [31:0]        w_sum;
   logic [31:0]        w_act;
   logic               w_better;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_L1_MAC;
         S_L1_MAC: if (r_k == K1_LAST) w_next = S_L1_WB;
         S_L1_WB:  w_next = (r_j == J1_LAST) ? S_L2_MAC : S_L1_MAC;
         S_L2_MAC: if (r_k == K2_LAST) w_next = S_L2_CMP;
         S_L2_CMP: w_next = (r_j == J2_LAST) ? S_DONE : S_L2_MAC;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // MAC datapath: the product of the previous issue lands this cycle (none at k=0)
   always_comb begin
      w_opa    = (r_state == S_L2_MAC || r_state == S_L2_CMP) ? hid_rdata : img_rdata;
      w_prod   = w_opa * w_rdata;
      w_add_en = (r_state == S_L1_WB) || (r_state == S_L2_CMP) ||
                 (((r_state == S_L1_MAC) || (r_state == S_L2_MAC)) && (r_k != '0));
      w_sum    = r_acc + (w_add_en ? w_prod : 32'd0);
`ifdef MNIST_SEQ_RELU_EN
      w_act    = ($signed(w_sum) > 32'sd0) ? w_sum : 32'd0;
`else
      w_act    = w_sum;
`endif
      w_better = (r_j == '0) || ($signed(w_sum) > $signed(r_best));
   end

   // Counters, accumulator, argmax tracker and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k           <= '0;
         r_j           <= '0;
         r_acc         <= '0;
         r_best        <= '0;
         r_best_idx    <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class_idx   <= '0;
         r_class_score <= '0;
         r_img_addr    <= '0;
         r_w_sel       <= 1'b0;
         r_w_addr      <= '0;
         r_hid_we      <= 1'b0;
         r_hid_addr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_busy     <= 1'b1;
                  r_k        <= '0;
                  r_j        <= '0;
                  r_acc      <= '0;
                  r_img_addr <= '0;
                  r_w_addr   <= '0;
                  r_w_sel    <= 1'b0;
                  r_hid_addr <= '0;
               end
            end
            S_L1_MAC: begin
               r_acc <= w_sum;
               if (r_k == K1_LAST) begin
                  r_hid_we   <= 1'b1;
                  r_hid_addr <= r_j;
               end else begin
                  r_k        <= r_k + 1'b1;
                  r_img_addr <= r_k + 1'b1;
                  r_w_addr   <= r_w_addr + HID_STEP;
               end
            end
            S_L1_WB: begin
               r_hid_we   <= 1'b0;
               r_acc      <= '0;
               r_k        <= '0;
               r_img_addr <= '0;
               if (r_j == J1_LAST) begin
                  r_j        <= '0;
                  r_w_sel    <= 1'b1;
                  r_w_addr   <= '0;
                  r_hid_addr <= '0;
               end else begin
                  r_j        <= r_j + 1'b1;
                  r_w_addr   <= r_j + 1'b1;
               end
            end
            S_L2_MAC: begin
               r_acc <= w_sum;
               if (r_k != K2_LAST) begin
                  r_k        <= r_k + 1'b1;
                  r_hid_addr <= r_k + 1'b1;
                  r_w_addr   <= r_w_addr + OUT_STEP;
               end
            end
            S_L2_CMP: begin
               r_acc      <= '0;
               r_k        <= '0;
               r_hid_addr <= '0;
               if (w_better) begin
                  r_best     <= w_sum;
                  r_best_idx <= IDX_W'(r_j);
               end
               if (r_j == J2_LAST) begin
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_class_idx   <= w_better ? IDX_W'(r_j) : r_best_idx;
                  r_class_score <= w_better ? w_sum : r_best;
                  r_w_addr      <= '0;
                  r_w_sel       <= 1'b0;
               end else begin
                  r_j      <= r_j + 1'b1;
                  r_w_addr <= r_j + 1'b1;
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
            end
            default: begin
               r_done   <= 1'b0;
               r_hid_we <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign class_idx   = r_class_idx;
   assign class_score = r_class_score;
   assign img_addr    = r_img_addr;
   assign w_sel       = r_w_sel;
   assign w_addr      = r_w_addr;
   assign hid_we      = r_hid_we;
   assign hid_addr    = r_hid_addr;
   // Final sum is only complete in the write-back cycle, so the write data is combinational
   assign hid_wdata   = w_act;

endmodule

// File: tb/tb_mnist_sequencer.sv
// Self-checking bench for mnist_sequencer on a reduced network, with a behavioural reference model.
module tb_mnist_sequencer;

   localparam int unsigned IN  = 6;
   localparam int unsigned HID = 4;
   localparam int unsigned OUT = 4;
   localparam int unsigned AW  = 8;
   localparam int unsigned IW  = 3;
   localparam int          LAT = HID * (IN + 1) + OUT * (HID + 1);
`ifdef MNIST_SEQ_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [IW-1:0] class_idx;
   logic [31:0]   class_score;
   logic [AW-1:0] img_addr;
   logic [31:0]   img_rdata;
   logic          w_sel;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_rdata;
   logic          hid_we;
   logic [AW-1:0] hid_addr;
   logic [31:0]   hid_wdata;
   logic [31:0]   hid_rdata;

   mnist_sequencer #(
      .IN_SIZE(IN), .HID_SIZE(HID), .OUT_SIZE(OUT), .ADDR_W(AW), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .class_idx(class_idx), .class_score(class_score),
      .img_addr(img_addr), .img_rdata(img_rdata),
      .w_sel(w_sel), .w_addr(w_addr), .w_rdata(w_rdata),
      .hid_we(hid_we), .hid_addr(hid_addr), .hid_wdata(hid_wdata), .hid_rdata(hid_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] img_mem [256];
   logic [31:0] w1_mem  [256];
   logic [31:0] w2_mem  [256];
   logic [31:0] hid_mem [256];

   // Synchronous memories: data valid one cycle after the address
   always @(posedge clk) begin
      img_rdata <= img_mem[img_addr];
      w_rdata   <= w_sel ? w2_mem[w_addr] : w1_mem[w_addr];
      hid_rdata <= hid_mem[hid_addr];
      if (hid_we) hid_mem[hid_addr] <= hid_wdata;
   end

   logic [AW-1:0] wr_addr [$];
   logic [31:0]   wr_data [$];
   int            done_cnt = 0;

   always @(negedge clk) begin
      if (hid_we) begin
         wr_addr.push_back(hid_addr);
         wr_data.push_back(hid_wdata);
      end
      if (done) done_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   logic [31:0]   exp_hid [HID];
   logic [31:0]   exp_score;
   int            exp_idx;
   logic [IW-1:0] prev_idx;
   logic [31:0]   prev_score;
   int            last_wb;

   // Reference: plain dot products with 32-bit wraparound, then first-maximum argmax
   task automatic model_run();
      logic [31:0] s;
      logic [31:0] outv [OUT];
      for (int j = 0; j < HID; j++) begin
         s = '0;
         for (int k = 0; k < IN; k++) s = s + img_mem[AW'(k)] * w1_mem[AW'(k * HID + j)];
         exp_hid[j] = (RELU && $signed(s) <= 0) ? 32'd0 : s;
      end
      for (int c = 0; c < OUT; c++) begin
         s = '0;
         for (int j = 0; j < HID; j++) s = s + exp_hid[j] * w2_mem[AW'(j * OUT + c)];
         outv[c] = s;
      end
      exp_idx = 0;
      for (int c = 1; c < OUT; c++)
         if ($signed(outv[c]) > $signed(outv[exp_idx])) exp_idx = c;
      exp_score = outv[exp_idx];
   endtask

   task automatic clear_mems();
      for (int i = 0; i < 256; i++) begin
         img_mem[i] = '0;
         w1_mem[i]  = '0;
         w2_mem[i]  = '0;
      end
   endtask

   function automatic logic [31:0] rnd(input int unsigned span);
      if (span == 0) return $urandom;
      return 32'(int'($urandom_range(2 * span)) - int'(span));
   endfunction

   task automatic fill_random(input int unsigned span);
      clear_mems();
      for (int i = 0; i < IN; i++)       img_mem[i] = rnd(span);
      for (int i = 0; i < IN * HID; i++) w1_mem[i]  = rnd(span);
      for (int i = 0; i < HID * OUT; i++) w2_mem[i] = rnd(span);
   endtask

   // One inference: latency, class result, ignored starts, single done, hidden writes
   task automatic run_check(input string tag);
      int lat;
      int db;
      model_run();
      last_wb = wr_data.size();
      db = done_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk({tag, ":busy_start"}, 32'(busy), 32'd1);
      lat = 0;
      for (int c = 1; c <= LAT + 20; c++) begin
         @(posedge clk); #1;
         if (c == 5) start = 1'b1;
         if (c == 6) start = 1'b0;
         if (c == 10) begin
            chk({tag, ":hold_idx"}, 32'(class_idx), 32'(prev_idx));
            chk({tag, ":hold_score"}, class_score, prev_score);
         end
         if (done) begin
            lat = c;
            break;
         end
      end
      chk({tag, ":latency"}, 32'(lat), 32'(LAT));
      chk({tag, ":busy_done"}, 32'(busy), 32'd0);
      chk({tag, ":class_idx"}, 32'(class_idx), 32'(exp_idx));
      chk({tag, ":class_score"}, class_score, exp_score);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ":start_in_done"}, 32'(busy), 32'd0);
      chk({tag, ":done_pulses"}, 32'(done_cnt - db), 32'd1);
      chk({tag, ":hid_writes"}, 32'(wr_data.size() - last_wb), 32'(HID));
      for (int j = 0; j < HID; j++) begin
         if (last_wb + j < wr_data.size()) begin
            chk({tag, ":hid_addr"}, 32'(wr_addr[last_wb + j]), 32'(j));
            chk({tag, ":hid_data"}, wr_data[last_wb + j], exp_hid[j]);
         end
      end
      prev_idx   = IW'(exp_idx);
      prev_score = exp_score;
   endtask

   task automatic chk_hid(input string tag, input int j, input logic [31:0] exp);
      if (last_wb + j < wr_data.size()) chk(tag, wr_data[last_wb + j], exp);
      else chk(tag, 32'hDEAD_BEEF, exp);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clear_mems();
      for (int i = 0; i < 256; i++) hid_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst:busy", 32'(busy), 32'd0);
      chk("rst:done", 32'(done), 32'd0);
      chk("rst:class_idx", 32'(class_idx), 32'd0);
      chk("rst:class_score", class_score, 32'd0);
      chk("rst:hid_we", 32'(hid_we), 32'd0);
      chk("rst:img_addr", 32'(img_addr), 32'd0);
      chk("rst:w_addr", 32'(w_addr), 32'd0);
      chk("rst:hid_addr", 32'(hid_addr), 32'd0);
      @(negedge clk) rst = 1'b0;
      prev_idx = '0;
      prev_score = '0;

      // identity-like weights
      clear_mems();
      for (int k = 0; k < IN; k++) img_mem[k] = 32'(k + 1);
      for (int k = 0; k < HID; k++) w1_mem[k * HID + k] = 32'd1;
      for (int j = 0; j < OUT; j++) w2_mem[j * OUT + j] = 32'd1;
      run_check("ident");
      chk_hid("ident:h2", 2, 32'd3);
      chk("ident:idx", 32'(class_idx), 32'd3);

      // hidden neuron 1 = -7
      clear_mems();
      img_mem[0] = 32'd1;
      w1_mem[0] = 32'd1;
      w1_mem[1] = 32'hFFFF_FFF9;
      w2_mem[0] = 32'd2;
      w2_mem[1 * OUT + 1] = 32'd3;
      run_check("neg_hidden");
      chk_hid("neg_hidden:h1", 1, RELU ? 32'd0 : 32'hFFFF_FFF9);

      // tie keeps lower index
      clear_mems();
      img_mem[0] = 32'd1;
      w1_mem[0] = 32'd1;
      w2_mem[0] = 32'd5; w2_mem[1] = 32'd9; w2_mem[2] = 32'd9; w2_mem[3] = 32'hFFFF_FFFD;
      run_check("tie");
      chk("tie:idx", 32'(class_idx), 32'd1);
      chk("tie:score", class_score, 32'd9);

      // all-negative scores
      w2_mem[0] = 32'hFFFF_FFF8; w2_mem[1] = 32'hFFFF_FFFE;
      w2_mem[2] = 32'hFFFF_FFFB; w2_mem[3] = 32'hFFFF_FFF7;
      run_check("allneg");
      chk("allneg:idx", 32'(class_idx), 32'd1);
      chk("allneg:score", class_score, 32'hFFFF_FFFE);

      // 4 x 0x40000000 wraps to zero
      clear_mems();
      for (int k = 0; k < 4; k++) begin
         img_mem[k] = 32'h4000_0000;
         w1_mem[k * HID] = 32'd1;
      end
      w1_mem[1] = 32'd1;
      w2_mem[0] = 32'd1; w2_mem[1 * OUT + 2] = 32'd1;
      run_check("wrap");
      chk_hid("wrap:h0", 0, 32'd0);

      for (int r = 0; r < 3; r++) begin
         fill_random(50);
         run_check("rand_small");
      end
      fill_random(0);
      run_check("rand_full");

      // reset in the middle of layer 1
      fill_random(100);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst:busy", 32'(busy), 32'd0);
      chk("midrst:hid_we", 32'(hid_we), 32'd0);
      chk("midrst:done", 32'(done), 32'd0);
      chk("midrst:class_idx", 32'(class_idx), 32'd0);
      chk("midrst:class_score", class_score, 32'd0);
      last_wb = wr_data.size();
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst:idle", 32'(busy), 32'd0);
      chk("midrst:no_writes", 32'(wr_data.size() - last_wb), 32'd0);
      prev_idx = '0;
      prev_score = '0;
      run_check("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
